// File: rtl/axi4lite_mem_slave.sv
// axi4lite_mem_slave: AXI4-lite word RAM slave with a console byte port and optional pseudo-random handshake stalls.
module axi4lite_mem_slave #(
    parameter int          MEM_WORDS    = 16384,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter              INIT_FILE    = "",
    parameter bit          STALL_EN     = 1'b0,
    parameter logic [63:0] STALL_SEED   = 64'd88172645463325252
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,
    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,
    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,
    output logic [1:0]  mem_axi_bresp,
    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,
    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,
    output logic [1:0]  mem_axi_rresp,
    output logic        console_valid,
    input  logic        console_ready,
    output logic [7:0]  console_data,
    output logic        err_oob,
    output logic [31:0] fetch_count
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_COLLECT, W_EXEC, W_CONS, W_RESP} w_state_t;

    logic [31:0] mem [MEM_WORDS];

    // Stall bits are taken from the state the generator holds in the cycle they gate.
    logic [63:0] lfsr, lfsr_n, x1, x2;
    logic [4:0] stall_n;

    always_comb begin
        x1 = lfsr ^ (lfsr << 13);
        x2 = x1 ^ (x1 >> 7);
        lfsr_n = x2 ^ (x2 << 17);
        stall_n = STALL_EN ? lfsr_n[4:0] : 5'd0;
    end

    always_ff @(posedge clk) lfsr <= !resetn ? STALL_SEED : lfsr_n;

    r_state_t r_state, r_next;
    logic ar_hs, r_hs, ar_in, fetch_q, arready_d, rvalid_d;

    assign ar_hs = mem_axi_arvalid && mem_axi_arready;
    assign r_hs = mem_axi_rvalid && mem_axi_rready;
    assign ar_in = {1'b0, mem_axi_araddr} < MEM_BYTES;

    always_comb begin
        r_next = (r_state == R_IDLE) ? (ar_hs ? R_RESP : R_IDLE) : (r_hs ? R_IDLE : R_RESP);
        arready_d = r_next == R_IDLE && !stall_n[0];
        rvalid_d = r_next == R_RESP && (mem_axi_rvalid || !stall_n[3]);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            mem_axi_arready <= 1'b0;
            mem_axi_rvalid <= 1'b0;
            mem_axi_rdata <= 32'd0;
            mem_axi_rresp <= 2'b00;
            fetch_q <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            r_state <= r_next;
            mem_axi_arready <= arready_d;
            mem_axi_rvalid <= rvalid_d;
            if (ar_hs) begin
                mem_axi_rdata <= ar_in ? mem[mem_axi_araddr[AW+1:2]] : 32'd0;
                mem_axi_rresp <= ar_in ? 2'b00 : 2'b10;
                fetch_q <= mem_axi_arprot[2];
            end
            if (r_hs && fetch_q) fetch_count <= fetch_count + 32'd1;
        end
    end

    w_state_t w_state, w_next;
    logic aw_held, w_held, aw_held_d, w_held_d;
    logic aw_hs, w_hs, b_hs, c_hs, aw_in, aw_cons;
    logic awready_d, wready_d, bvalid_d;
    logic [31:0] awaddr_q, wdata_q;
    logic [3:0] wstrb_q;

    assign aw_hs = mem_axi_awvalid && mem_axi_awready;
    assign w_hs = mem_axi_wvalid && mem_axi_wready;
    assign b_hs = mem_axi_bvalid && mem_axi_bready;
    assign c_hs = console_valid && console_ready;
    assign aw_in = {1'b0, awaddr_q} < MEM_BYTES;
    assign aw_cons = awaddr_q[31:2] == CONSOLE_ADDR[31:2];

    always_comb begin
        aw_held_d = b_hs ? 1'b0 : aw_held || aw_hs;
        w_held_d = b_hs ? 1'b0 : w_held || w_hs;
        w_next = w_state;
        case (w_state)
            W_COLLECT: w_next = (aw_held_d && w_held_d) ? W_EXEC : W_COLLECT;
            W_EXEC:    w_next = (!aw_in && aw_cons) ? W_CONS : W_RESP;
            W_CONS:    w_next = c_hs ? W_RESP : W_CONS;
            default:   w_next = b_hs ? W_COLLECT : W_RESP;
        endcase
        awready_d = w_next == W_COLLECT && !aw_held_d && !stall_n[1];
        wready_d = w_next == W_COLLECT && !w_held_d && !stall_n[2];
        bvalid_d = w_next == W_RESP && (mem_axi_bvalid || !stall_n[4]);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state <= W_COLLECT;
            aw_held <= 1'b0;
            w_held <= 1'b0;
            awaddr_q <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            mem_axi_awready <= 1'b0;
            mem_axi_wready <= 1'b0;
            mem_axi_bvalid <= 1'b0;
            mem_axi_bresp <= 2'b00;
            console_valid <= 1'b0;
            console_data <= 8'd0;
            err_oob <= 1'b0;
        end else begin
            w_state <= w_next;
            aw_held <= aw_held_d;
            w_held <= w_held_d;
            mem_axi_awready <= awready_d;
            mem_axi_wready <= wready_d;
            mem_axi_bvalid <= bvalid_d;
            if (aw_hs) awaddr_q <= mem_axi_awaddr;
            if (w_hs) begin
                wdata_q <= mem_axi_wdata;
                wstrb_q <= mem_axi_wstrb;
            end
            if (w_state == W_EXEC) begin
                mem_axi_bresp <= (aw_in || aw_cons) ? 2'b00 : 2'b10;
                console_valid <= !aw_in && aw_cons;
                if (!aw_in && aw_cons) console_data <= wdata_q[7:0];
            end
            if (c_hs) console_valid <= 1'b0;
            err_oob <= err_oob || (ar_hs && !ar_in) || (w_state == W_EXEC && !aw_in && !aw_cons);
        end
    end

    // RAM has no reset; a commit is suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (resetn && w_state == W_EXEC && aw_in)
            for (int b = 0; b < 4; b++)
                if (wstrb_q[b]) mem[awaddr_q[AW+1:2]][8*b +: 8] <= wdata_q[8*b +: 8];
    end

    logic unused_ok;
    assign unused_ok = ^{mem_axi_awprot, mem_axi_arprot[1:0], mem_axi_araddr[1:0], awaddr_q[1:0], lfsr_n[63:5]};
endmodule

// File: tb/tb_axi4lite_mem_slave.sv
// tb_axi4lite_mem_slave: scoreboard bench; directed tests on an unstalled instance, random soak on a stalled one.
module tb_axi4lite_mem_slave;
    localparam logic [1:0] OK = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic awvalid[2], awready[2], wvalid[2], wready[2], bvalid[2], bready[2];
    logic arvalid[2], arready[2], rvalid[2], rready[2];
    logic console_valid[2], console_ready[2], err_oob[2];
    logic [31:0] awaddr[2], wdata[2], araddr[2], rdata[2], fetch_count[2];
    logic [3:0] wstrb[2];
    logic [2:0] awprot[2], arprot[2];
    logic [1:0] bresp[2], rresp[2];
    logic [7:0] console_data[2];

    for (genvar i = 0; i < 2; i++) begin : g_dut
        axi4lite_mem_slave #(
            .MEM_WORDS(i == 0 ? 16384 : 64),
            .STALL_EN(i == 1)
        ) dut (
            .clk(clk), .resetn(resetn),
            .mem_axi_awvalid(awvalid[i]), .mem_axi_awready(awready[i]),
            .mem_axi_awaddr(awaddr[i]), .mem_axi_awprot(awprot[i]),
            .mem_axi_wvalid(wvalid[i]), .mem_axi_wready(wready[i]),
            .mem_axi_wdata(wdata[i]), .mem_axi_wstrb(wstrb[i]),
            .mem_axi_bvalid(bvalid[i]), .mem_axi_bready(bready[i]), .mem_axi_bresp(bresp[i]),
            .mem_axi_arvalid(arvalid[i]), .mem_axi_arready(arready[i]),
            .mem_axi_araddr(araddr[i]), .mem_axi_arprot(arprot[i]),
            .mem_axi_rvalid(rvalid[i]), .mem_axi_rready(rready[i]),
            .mem_axi_rdata(rdata[i]), .mem_axi_rresp(rresp[i]),
            .console_valid(console_valid[i]), .console_ready(console_ready[i]),
            .console_data(console_data[i]),
            .err_oob(err_oob[i]), .fetch_count(fetch_count[i])
        );
    end

    int checks = 0, errors = 0, nwr = 0, nb = 0, nfetch = 0, noob = 0;
    logic [33:0] rq[$];
    logic [1:0] bq[$];
    logic [33:0] r_e;
    logic [31:0] model[64];
    bit pend_r[2], pend_b[2];
    bit soak_on;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Pops the scoreboard on every completed R/B handshake and watches for valids withdrawn early.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (pend_r[d]) check("r_hold", rvalid[d], 1);
            if (pend_b[d]) check("b_hold", bvalid[d], 1);
            pend_r[d] = resetn && rvalid[d] && !rready[d];
            pend_b[d] = resetn && bvalid[d] && !bready[d];
            if (resetn && rvalid[d] && rready[d]) begin
                check("r_sb", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    r_e = rq.pop_front();
                    check("rdata", rdata[d], r_e[31:0]);
                    check("rresp", rresp[d], r_e[33:32]);
                end
            end
            if (resetn && bvalid[d] && bready[d]) begin
                nb++;
                check("b_sb", bq.size() != 0, 1);
                if (bq.size() != 0) check("bresp", bresp[d], bq.pop_front());
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && (rq.size() + bq.size()) != 0; n++) @(posedge clk);
        check("drain", 32'(rq.size() + bq.size()), 0);
        cyc(1);
    endtask

    task automatic do_aw(int d, logic [31:0] a);
        awaddr[d] = a;
        awvalid[d] = 1;
        for (int n = 0; n < 100 && !awready[d]; n++) @(negedge clk);
        check("aw_ready", awready[d], 1);
        @(posedge clk);
        #1;
        awvalid[d] = 0;
    endtask

    task automatic do_w(int d, logic [31:0] v, logic [3:0] s);
        wdata[d] = v;
        wstrb[d] = s;
        wvalid[d] = 1;
        for (int n = 0; n < 100 && !wready[d]; n++) @(negedge clk);
        check("w_ready", wready[d], 1);
        @(posedge clk);
        #1;
        wvalid[d] = 0;
    endtask

    task automatic do_ar(int d, logic [31:0] a, logic [2:0] p);
        araddr[d] = a;
        arprot[d] = p;
        arvalid[d] = 1;
        for (int n = 0; n < 100 && !arready[d]; n++) @(negedge clk);
        check("ar_ready", arready[d], 1);
        @(posedge clk);
        #1;
        arvalid[d] = 0;
    endtask

    task automatic wr(int d, logic [31:0] a, logic [31:0] v, logic [3:0] s, logic [1:0] er, int dly, bit wfirst);
        bq.push_back(er);
        nwr++;
        fork
            begin cyc(wfirst ? dly : 0); do_aw(d, a); end
            begin cyc(wfirst ? 0 : dly); do_w(d, v, s); end
        join
        drain();
    endtask

    task automatic rd(int d, logic [31:0] a, logic [2:0] p, logic [33:0] exp);
        rq.push_back(exp);
        do_ar(d, a, p);
        if (d == 0) check("r_lat", rvalid[0], 1);
        drain();
    endtask

    task automatic soak_op();
        int idx = $urandom_range(0, 63);
        int kind = $urandom_range(0, 7);
        logic [31:0] a = 32'(idx * 4) + 32'($urandom_range(0, 3));
        logic [31:0] v = $urandom;
        logic [3:0] s = 4'($urandom);
        logic [2:0] p = 3'($urandom);
        logic [31:0] oa = 32'h100 + 32'($urandom_range(0, 4095) * 4);
        if (kind < 4) begin
            if (p[2]) nfetch++;
            rd(1, a, p, {OK, model[idx]});
        end else if (kind < 7) begin
            for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = v[8*b +: 8];
            wr(1, a, v, s, OK, $urandom_range(0, 3), 1'($urandom));
        end else begin
            noob++;
            if (v[0]) rd(1, oa, 3'b000, {ERR, 32'h0});
            else wr(1, oa, v, s, ERR, 0, 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            awvalid[d] = 0; wvalid[d] = 0; arvalid[d] = 0;
            bready[d] = 1; rready[d] = 1; console_ready[d] = 1;
            awaddr[d] = 0; wdata[d] = 0; wstrb[d] = 0; araddr[d] = 0;
            awprot[d] = 0; arprot[d] = 0;
        end
        cyc(3);
        check("rst_ctl", {arready[0], awready[0], wready[0], rvalid[0], bvalid[0], bresp[0], rresp[0],
                          console_valid[0], console_data[0], err_oob[0]}, 0);
        check("rst_data", {rdata[0], fetch_count[0]}, 0);
        resetn = 1;
        cyc(1);
        check("rdy_rise", {arready[0], awready[0], wready[0]}, 3'b111);

        wr(0, 32'h0, 32'h0000_0013, 4'hf, OK, 0, 0);
        rd(0, 32'h0, 3'b100, {OK, 32'h0000_0013});
        check("fetch1", fetch_count[0], 1);

        wr(0, 32'h10, 32'hAABB_CCDD, 4'hf, OK, 0, 0);
        wr(0, 32'h10, 32'h1122_3344, 4'b0101, OK, 0, 0);
        rd(0, 32'h10, 3'b000, {OK, 32'hAA22_CC44});
        wr(0, 32'h10, 32'hFFFF_FFFF, 4'b0000, OK, 0, 0);
        rd(0, 32'h13, 3'b000, {OK, 32'hAA22_CC44});

        wr(0, 32'h20, 32'h0101_0101, 4'hf, OK, 3, 1);
        wr(0, 32'h24, 32'h0202_0202, 4'hf, OK, 3, 0);
        wr(0, 32'h28, 32'h0303_0303, 4'hf, OK, 0, 0);
        rd(0, 32'h20, 3'b000, {OK, 32'h0101_0101});
        rd(0, 32'h24, 3'b000, {OK, 32'h0202_0202});
        rd(0, 32'h28, 3'b000, {OK, 32'h0303_0303});
        check("b_count", nb, nwr);

        console_ready[0] = 0;
        bq.push_back(OK);
        nwr++;
        fork
            do_aw(0, 32'h1000_0000);
            do_w(0, 32'h0000_0041, 4'h1);
        join
        for (int n = 0; n < 20 && !console_valid[0]; n++) cyc(1);
        for (int n = 0; n < 5; n++) begin
            check("con_valid", console_valid[0], 1);
            check("con_data", console_data[0], 8'h41);
            check("con_bvalid", bvalid[0], 0);
            cyc(1);
        end
        console_ready[0] = 1;
        cyc(1);
        check("con_drop", console_valid[0], 0);
        check("con_b", bvalid[0], 1);
        drain();

        check("oob_pre", err_oob[0], 0);
        rd(0, 32'h0001_0000, 3'b000, {ERR, 32'h0});
        check("oob_r", err_oob[0], 1);
        wr(0, 32'h2000_0000, 32'hDEAD_BEEF, 4'hf, ERR, 0, 0);
        wr(0, 32'h0001_0000, 32'hDEAD_BEEF, 4'hf, ERR, 0, 0);
        wr(0, 32'h0000_FFFC, 32'h5A5A_5A5A, 4'hf, OK, 0, 0);
        rd(0, 32'h0000_FFFC, 3'b100, {OK, 32'h5A5A_5A5A});
        rd(0, 32'h0, 3'b000, {OK, 32'h0000_0013});
        check("fetch2", fetch_count[0], 2);
        check("oob_sticky", err_oob[0], 1);
        check("b_count2", nb, nwr);

        for (int k = 0; k < 64; k++) begin
            model[k] = $urandom;
            wr(1, 32'(k * 4), model[k], 4'hf, OK, 0, 0);
        end
        soak_on = 1;
        fork
            while (soak_on) begin
                rready[1] = 1'($urandom);
                bready[1] = 1'($urandom);
                cyc(1);
            end
            begin
                for (int k = 0; k < 2500; k++) soak_op();
                soak_on = 0;
            end
        join
        rready[1] = 1;
        bready[1] = 1;
        check("soak_fetch", fetch_count[1], nfetch);
        check("soak_oob", err_oob[1], noob > 0);

        bready[1] = 0;
        rready[1] = 0;
        model[2] = 32'hCAFE_F00D;
        fork
            do_aw(1, 32'h8);
            do_w(1, 32'hCAFE_F00D, 4'hf);
        join
        for (int n = 0; n < 50 && !bvalid[1]; n++) cyc(1);
        do_ar(1, 32'h4, 3'b100);
        for (int n = 0; n < 50 && !rvalid[1]; n++) cyc(1);
        check("mid_valids", {rvalid[1], bvalid[1]}, 2'b11);
        resetn = 0;
        cyc(1);
        check("rst_mid", {rvalid[1], bvalid[1], arready[1], awready[1], wready[1], console_valid[1],
                          rvalid[0], bvalid[0], arready[0], awready[0], wready[0]}, 0);
        rq.delete();
        bq.delete();
        cyc(2);
        resetn = 1;
        rready[1] = 1;
        bready[1] = 1;
        cyc(2);
        check("rst_oob_clr", err_oob[0], 0);
        check("rst_fetch_clr", fetch_count[0], 0);
        rd(0, 32'h10, 3'b000, {OK, 32'hAA22_CC44});
        rd(0, 32'h0, 3'b000, {OK, 32'h0000_0013});
        rd(1, 32'h8, 3'b000, {OK, model[2]});
        rd(1, 32'h4, 3'b000, {OK, model[1]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
